ring_mux_nxm: RTL

Parametrised N-input, M-output flit crossbar-mux for hierarchical-ring router stops, generalising the fixed 4+2-input, 2-output control-word mux. Each input has a one-entry buffer with valid/ready flow control. Each output either takes a statically selected input or round-robin arbitrates among all inputs. Outputs are registered. The block sits between ring/local input ports and ring output links.

---
 rtl/ring_mux_pkg.sv | 24 ++
 rtl/ring_mux_nxm_if.sv | 28 ++
 rtl/ring_mux_nxm_rr_arbiter.sv | 55 +++++
 rtl/ring_mux_nxm.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ring_mux_pkg.sv
// Shared constants and helpers for the N-input, M-output ring flit mux.
package ring_mux_pkg;

    // Default flit / control-word width in bits.
    localparam int FLIT_W_DEFAULT = 144;

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Select code for round-robin mode: all ones at the given select width.
    function automatic int sel_auto(input int sel_w);
        return (1 << sel_w) - 1;
    endfunction

endpackage

// File: rtl/ring_mux_nxm_if.sv
// Flit-side bundle of the ring mux. The master drives input flits, selects and
// downstream ready. The slave is the mux itself.
interface ring_mux_nxm_if
    import ring_mux_pkg::*;
#(
    parameter int NUM_IN  = 6,
    parameter int NUM_OUT = 2,
    parameter int FLIT_W  = FLIT_W_DEFAULT,
    parameter int SEL_W   = clog2(NUM_IN + 1)
);
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN*FLIT_W-1:0]  in_data;
    logic [NUM_IN-1:0]         in_ready;
    logic [NUM_OUT*SEL_W-1:0]  sel;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT*FLIT_W-1:0] out_data;
    logic [NUM_OUT-1:0]        out_ready;

    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ring_mux_nxm_rr_arbiter.sv
// Round-robin arbiter for one mux output. It picks the first available input
// at or after its pointer, wrapping, and moves the pointer one past the winner.
module rr_arbiter
    import ring_mux_pkg::*;
#(
    parameter int NUM_IN = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req,
    input  logic [NUM_IN-1:0] mask,
    input  logic              enable,
    output logic [NUM_IN-1:0] grant
);
    localparam int PTR_W = clog2(NUM_IN);

    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  ptr_next;
    logic [NUM_IN-1:0] avail;
    logic              found;

    assign avail = enable ? (req & ~mask) : '0;

    // Two passes: first the inputs at or above the pointer, then wrap to the
    // bottom. This avoids computing a variable rotated index.
    always_comb begin
        grant    = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!found && avail[i] && (PTR_W'(i) >= ptr_reg)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                ptr_next = (i == NUM_IN - 1) ? '0 : PTR_W'(i + 1);
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (!found && avail[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                ptr_next = (i == NUM_IN - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // The pointer advances only on a grant. Otherwise ptr_next equals ptr_reg.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/ring_mux_nxm.sv
// N-input, M-output flit mux for a ring router stop. It has one-entry input
// buffers, and each output is either statically selected or round-robin. An
// output claims an input in ascending output order, so a flit never goes to
// two outputs.
module ring_mux_nxm
    import ring_mux_pkg::*;
#(
    parameter int NUM_IN  = 6,
    parameter int NUM_OUT = 2,
    parameter int FLIT_W  = FLIT_W_DEFAULT,
    parameter int SEL_W   = clog2(NUM_IN + 1)
) (
    input  logic           clk,
    input  logic           rst,
    ring_mux_nxm_if.slave  bus
);
    localparam logic [SEL_W-1:0] SEL_AUTO = SEL_W'(sel_auto(SEL_W));
    localparam logic [SEL_W-1:0] NUM_IN_S = SEL_W'(NUM_IN);

    logic [NUM_IN-1:0]         buf_v;
    logic [FLIT_W-1:0]         buf_d [NUM_IN];
    logic [NUM_IN-1:0]         drain;
    logic [NUM_IN-1:0]         load;
    logic [NUM_OUT-1:0]        out_valid_flat;
    logic [NUM_OUT*FLIT_W-1:0] out_data_flat;

    // A buffer accepts when empty or when it is being drained this cycle.
    assign bus.in_ready = rst ? (~buf_v | drain) : '0;
    assign load         = bus.in_valid & bus.in_ready;

    genvar gi;

    // One-entry input buffers.
    for (gi = 0; gi < NUM_IN; gi++) begin : g_buf
        logic              v_reg;
        logic [FLIT_W-1:0] d_reg;

        // Valid flag: a load wins over a drain, which gives back-to-back throughput.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_reg <= 1'b0;
            end else if (load[gi]) begin
                v_reg <= 1'b1;
            end else if (drain[gi]) begin
                v_reg <= 1'b0;
            end
        end

        // Payload needs no reset because it is qualified by v_reg.
        always_ff @(posedge clk) begin
            if (load[gi]) begin
                d_reg <= bus.in_data[gi*FLIT_W +: FLIT_W];
            end
        end

        assign buf_v[gi] = v_reg;
        assign buf_d[gi] = d_reg;
    end

    // Output stages. mask_in holds the inputs already claimed by lower outputs.
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
        logic [SEL_W-1:0]  sel_j;
        logic              is_auto;
        logic              is_static;
        logic              loadable;
        logic [NUM_IN-1:0] mask_in;
        logic [NUM_IN-1:0] mask_out;
        logic [NUM_IN-1:0] static_grant;
        logic [NUM_IN-1:0] rr_grant;
        logic [NUM_IN-1:0] grant;
        logic [FLIT_W-1:0] data_mux;
        logic              v_reg;
        logic [FLIT_W-1:0] d_reg;

        if (gi == 0) begin : g_head
            assign mask_in = '0;
        end else begin : g_link
            assign mask_in = g_out[gi-1].mask_out;
        end

        assign sel_j     = bus.sel[gi*SEL_W +: SEL_W];
        assign is_auto   = (sel_j == SEL_AUTO);
        assign is_static = (sel_j < NUM_IN_S);
        assign loadable  = !v_reg || bus.out_ready[gi];

        // Static select: take input sel_j if it holds a flit nobody claimed yet.
        always_comb begin
            static_grant = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                static_grant[i] = is_static && loadable && (sel_j == SEL_W'(i))
                                  && buf_v[i] && !mask_in[i];
            end
        end

        rr_arbiter #(
            .NUM_IN (NUM_IN)
        ) u_arb (
            .clk    (clk),
            .rst    (rst),
            .req    (buf_v),
            .mask   (mask_in),
            .enable (is_auto && loadable),
            .grant  (rr_grant)
        );

        assign grant    = static_grant | rr_grant;
        assign mask_out = mask_in | grant;

        // One-hot AND-OR mux of the granted buffer.
        always_comb begin
            data_mux = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (grant[i]) begin
                    data_mux = data_mux | buf_d[i];
                end
            end
        end

        // Output register: load on a grant, clear on consume, otherwise hold.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_reg <= 1'b0;
                d_reg <= '0;
            end else if (|grant) begin
                v_reg <= 1'b1;
                d_reg <= data_mux;
            end else if (bus.out_ready[gi]) begin
                v_reg <= 1'b0;
            end
        end

        assign out_valid_flat[gi]                 = v_reg;
        assign out_data_flat[gi*FLIT_W +: FLIT_W] = d_reg;
    end

    // The final claim mask is exactly the set of buffers drained this cycle.
    assign drain         = g_out[NUM_OUT-1].mask_out;
    assign bus.out_valid = out_valid_flat;
    assign bus.out_data  = out_data_flat;

endmodule
